// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 program loader: packs bytes into 32-bit words, writes instruction memory, releases core reset.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  input  logic              en_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              byte_valid_o,
  output logic [7:0]        rx_byte_o,
  output logic              frame_err_o,
  output logic              prog_done_o,
  output logic              core_rst_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t            state;
  logic              rx_m, rx_s;
  logic [TW-1:0]     timer;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [1:0]        byte_cnt;
  logic [31:0]       word;
  logic [31:0]       full_word;
  logic [ADDR_W-1:0] word_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_valid_o <= 1'b0;
      rx_byte_o    <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      if (!en_i || prog_done_o) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              timer <= '0;
            end
          end
          // Re-check the start bit at mid-bit; from here on every sample lands mid-bit.
          START: begin
            if (timer == HALF_T) begin
              timer   <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DATA: begin
            if (timer == FULL_T) begin
              timer          <= '0;
              shift[bit_idx] <= rx_s;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          STOP: begin
            if (timer == FULL_T) begin
              timer <= '0;
              if (rx_s) begin
                rx_byte_o    <= shift;
                byte_valid_o <= 1'b1;
                state        <= IDLE;
              end else begin
                frame_err_o <= 1'b1;
                state       <= WAIT_IDLE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          WAIT_IDLE: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    full_word = word;
    full_word[{byte_cnt, 3'b000} +: 8] = rx_byte_o;
  end

  // Word packer; a write to the last address also ends loading since there is no wrap.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      prog_done_o <= 1'b0;
      core_rst_o  <= 1'b1;
      byte_cnt    <= '0;
      word        <= '0;
      word_cnt    <= '0;
    end else begin
      mem_we_o   <= 1'b0;
      core_rst_o <= !prog_done_o;
      if (!en_i) begin
        byte_cnt <= '0;
        word     <= '0;
      end else if (byte_valid_o && !prog_done_o) begin
        word     <= full_word;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (full_word == END_WORD) begin
            prog_done_o <= 1'b1;
          end else begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= word_cnt;
            mem_wdata_o <= full_word;
            word_cnt    <= word_cnt + 1'b1;
            if (word_cnt == '1) prog_done_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits in the user project directly downstream of the external serial programmer that drives mprj_io[5].
- Receives a program image over UART (8N1, LSB first) and packs bytes little-endian into 32-bit words.
- Writes each word sequentially into instruction memory.
- Holds the core in reset until an end-of-program marker word arrives or memory fills, then releases it.

Parameters:
- CLKS_PER_BIT, 434, wb_clk_i cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 8, instruction-memory word-address width; depth is 2^ADDR_W words.
- END_WORD, 32'h00000FFF, marker word that terminates loading; it is never written to memory.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous serial line; idles high.
- en_i  input  1  loader enable; low aborts and holds the receiver idle.
- mem_we_o  output  1  one-cycle memory write strobe.
- mem_addr_o  output  ADDR_W  word address for the write.
- mem_wdata_o  output  32  packed word.
- byte_valid_o  output  1  one-cycle pulse per good received byte.
- rx_byte_o  output  8  last good byte; held between pulses.
- frame_err_o  output  1  sticky; set on a bad stop bit.
- prog_done_o  output  1  sticky; loading finished.
- core_rst_o  output  1  core reset: high until prog_done_o, then low.

Behaviour:
- Reset values: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, byte_valid_o=0, rx_byte_o=0, frame_err_o=0, prog_done_o=0, core_rst_o=1. Internal: sync flops=1, FSM=IDLE, byte_cnt=0, word_cnt=0.
- rx_i passes through a 2-flop synchronizer (reset to 1). All sampling uses the synchronized value, rx_s.
- RX FSM, with a bit-timer counting 0..CLKS_PER_BIT-1:
  - IDLE: on rx_s==0 with en_i=1 and prog_done_o=0, go to START and clear the timer.
  - START: at timer==CLKS_PER_BIT/2-1, sample. If rx_s==0 go to DATA and clear the timer (mid-bit alignment). Otherwise treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift[bit_idx], LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample. If rx_s==1: rx_byte_o<=shift, byte_valid_o=1 for one cycle, go to IDLE. If rx_s==0: set frame_err_o, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE.
- Packer, on each byte_valid:
  - word[8*byte_cnt +: 8] <= byte; byte_cnt increments and wraps 3->0.
  - On the 4th byte, in the next cycle:
    - if word==END_WORD: prog_done_o<=1, no write;
    - else: mem_we_o=1 for one cycle, mem_addr_o=word_cnt, mem_wdata_o=word, then word_cnt++.
- Latency: byte_valid_o is 1 cycle after the stop-bit sample; mem_we_o is 1 cycle after the 4th byte_valid_o.
- Full: a write to address 2^ADDR_W-1 also sets prog_done_o in the same cycle. There is no wrap.
- After prog_done_o=1:
  - the RX FSM stays in IDLE and all input is ignored until wb_rst_i;
  - core_rst_o goes 0 in the cycle after prog_done_o rises.
- en_i=0 at any time: the FSM is forced to IDLE next cycle and the partial word plus byte_cnt are cleared. word_cnt, the sticky flags and memory writes already done are kept.
- wb_rst_i mid-frame or mid-word: everything returns to reset values next cycle, with no write strobe.
- Frame error: the partial word is kept, so the next good byte continues the word. Flag meaning: the image is corrupt.

Test Plan (CLKS_PER_BIT=8, ADDR_W=2):
1. Send bytes 0x13,0x05,0x10,0x00 -> one mem_we_o pulse with addr=0 and wdata=0x00100513; 4 byte_valid_o pulses with rx_byte_o matching each byte; core_rst_o still 1.
2. Send two words then 0xFF,0x0F,0x00,0x00 -> writes at addr 0 and 1; no third write; prog_done_o=1, then core_rst_o=0 one cycle later; further bytes cause no byte_valid_o.
3. Send 16 non-marker bytes -> writes at addr 0..3; prog_done_o set with the addr-3 write; a 5th word is ignored.
4. Drive a 3-cycle low glitch on rx_i -> no byte_valid_o, FSM back in IDLE; a following byte 0xA5 is received correctly.
5. Send 0x55 with stop bit=0 -> frame_err_o=1, no byte_valid_o; the line returns high, then 0x3C is received with byte_valid_o.
6. Assert wb_rst_i after 2 bytes (and separately pull en_i low after 2 bytes) -> no write; the next 4 bytes form a full word written at addr 0 after reset, or at the current word_cnt for the en_i case.
